// File: rtl/jt7759_fifo.sv
// rtl/jt7759_fifo.sv - uPD7759 sample-data prefetch FIFO, ROM master or CPU slave byte source.
// Optional sticky slave-overflow flag enabled by defining JT7759_FIFO_OVFL_EN.
module jt7759_fifo #(
   parameter  int DW    = 8,
   parameter  int AW    = 17,
   parameter  int DEPTH = 4,
   parameter  int GAP   = 31,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen_ctl,
   input  logic          mdn,
   input  logic          ctrl_flush,
   input  logic          ctrl_cs,
   input  logic          ctrl_busyn,
   input  logic [AW-1:0] ctrl_addr,
   output logic [DW-1:0] ctrl_din,
   output logic          ctrl_ok,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   input  logic          rom_ok,
   input  logic          cs,
   input  logic          wrn,
   input  logic [DW-1:0] din,
   output logic          drqn,
   output logic [LW-1:0] level,
   output logic          ovfl
);

   localparam int IW = $clog2(DEPTH);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [LW-1:0] wr_ptr, rd_ptr;
   logic [GW-1:0] gap_cnt;
   logic          drq_seen;
   logic          cs_l;
   logic          armed;
   logic          clr, full, wr_en, rd_en;
   logic [DW-1:0] wr_data;

   assign level   = wr_ptr - rd_ptr;
   assign full    = level == LW'(DEPTH);
   assign clr     = ctrl_busyn | ctrl_flush;
   assign rom_cs  = mdn & ~drqn;
   assign wr_data = mdn ? rom_data : din;
   // ROM data is trusted only once drqn has been low for a full cycle
   assign wr_en   = ~drqn & (mdn ? (drq_seen & rom_ok) : (cs & ~wrn));
   assign rd_en   = ctrl_cs & (armed | ~cs_l) & (level != '0);

   always_ff @(posedge clk) begin
      if (wr_en && !clr) mem[wr_ptr[IW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk, posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         gap_cnt  <= '0;
         drqn     <= 1'b1;
         drq_seen <= 1'b0;
         cs_l     <= 1'b0;
         armed    <= 1'b0;
         ctrl_ok  <= 1'b0;
         ctrl_din <= '0;
         rom_addr <= '0;
      end else begin
         cs_l     <= ctrl_cs;
         drq_seen <= ~drqn;
         if (cen_ctl && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;

         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            drqn   <= 1'b1;
         end else begin
            if (wr_en) begin
               wr_ptr  <= wr_ptr + 1'b1;
               drqn    <= 1'b1;
               gap_cnt <= GW'(GAP);
            end else if (drqn && !full && gap_cnt == '0) begin
               drqn <= 1'b0;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         end

         if (!ctrl_cs) begin
            ctrl_ok <= 1'b0;
            armed   <= 1'b0;
         end else if (rd_en && !clr) begin
            ctrl_din <= mem[rd_ptr[IW-1:0]];
            ctrl_ok  <= 1'b1;
            armed    <= 1'b0;
         end else if (!cs_l) begin
            ctrl_ok <= 1'b0;
            armed   <= 1'b1;
         end

         if (ctrl_flush) rom_addr <= ctrl_addr;
         else if (wr_en && mdn && !clr) rom_addr <= rom_addr + 1'b1;
      end
   end

`ifdef JT7759_FIFO_OVFL_EN
   always_ff @(posedge clk, posedge rst) begin
      if (rst) ovfl <= 1'b0;
      else if (!mdn && cs && !wrn && drqn && full) ovfl <= 1'b1;
   end
`else
   assign ovfl = 1'b0;
`endif

endmodule
